key_bank: RTL and testbench

KEY_BANK -- requirements
Module: key_bank

---
 rtl/key_pkg.sv | 20 ++
 rtl/ms_tick_gen.sv | 35 +++
 rtl/key_bank.sv | 183 ++++++++++++++++++
 tb/tb_key_bank.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the key_bank debouncer: channel FSM states and
// the sclk-cycles-per-millisecond conversion used by the tick generator.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        REPEAT,
        DEB_RELEASE
    } key_state_e;

    localparam int TICKS_PER_SEC = 1000;

    // Never returns zero, so very slow clocks still produce a tick every cycle.
    function automatic int ms_tick_div(input int clk_freq);
        return (clk_freq / TICKS_PER_SEC < 1) ? 1 : clk_freq / TICKS_PER_SEC;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond tick: tick is high for one sclk cycle every
// CLK_FREQ/1000 cycles. One instance is shared by every key channel.
module ms_tick_gen
    import key_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic sclk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = ms_tick_div(CLK_FREQ);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          tick_q;

    // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (cnt_q == CW'(DIV - 1)) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            tick_q <= 1'b0;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/key_bank.sv
// Multi-channel key debouncer with press/release pulses, long-press hold and
// auto-repeat. Double-click detection is built only when KEY_BANK_DCLICK_EN is defined.
module key_bank
    import key_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int CH          = 4,
    parameter bit PRESS_LVL   = 1'b0,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 500,
    parameter int REPEAT_MS   = 100,
    parameter int DCLICK_MS   = 300
) (
    input  logic          sclk,
    input  logic          rst,
    input  logic [CH-1:0] key_in,
    output logic [CH-1:0] key_press,
    output logic [CH-1:0] key_release,
    output logic [CH-1:0] key_held,
    output logic [CH-1:0] key_dclick
);

    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam int LW = $clog2(LONG_MS + 1);
    localparam int RW = $clog2(REPEAT_MS + 1);
    localparam logic [CH-1:0] REL_LVL = {CH{~PRESS_LVL}};

    logic          tick;
    logic [CH-1:0] meta_q;
    logic [CH-1:0] sync_q;

    ms_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
        .sclk (sclk),
        .rst  (rst),
        .tick (tick)
    );

    // Synchronisers reset to the released level so reset never looks like a press.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            meta_q <= REL_LVL;
            sync_q <= REL_LVL;
        end else begin
            meta_q <= key_in;
            sync_q <= meta_q;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        key_state_e    state_q, state_d;
        logic [DW-1:0] deb_q, deb_d, deb_sat;
        logic [LW-1:0] long_q, long_d, long_sat;
        logic [RW-1:0] rep_q, rep_d;
        logic          held_q, held_d;
        logic          pressed, press, rel_pulse;

        assign pressed  = (sync_q[g] == PRESS_LVL);
        assign deb_sat  = (deb_q == DW'(DEBOUNCE_MS)) ? deb_q : deb_q + 1'b1;
        assign long_sat = (long_q == LW'(LONG_MS)) ? long_q : long_q + 1'b1;

        always_comb begin
            // NOTE: every comb output gets a default first, so no path can infer a latch.
            state_d   = state_q;
            deb_d     = deb_q;
            long_d    = long_q;
            rep_d     = rep_q;
            held_d    = held_q;
            press     = 1'b0;
            rel_pulse = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pressed) begin
                        state_d = DEB_PRESS;
                        deb_d   = '0;
                    end
                end
                DEB_PRESS: begin
                    if (!pressed) begin
                        state_d = IDLE;
                        deb_d   = '0;
                    end else if (tick) begin
                        deb_d = deb_sat;
                        if (deb_sat == DW'(DEBOUNCE_MS)) begin
                            state_d = PRESSED;
                            long_d  = '0;
                            press   = 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (!pressed) begin
                        state_d = DEB_RELEASE;
                        deb_d   = '0;
                    end else if (tick) begin
                        long_d = long_sat;
                        if (long_sat == LW'(LONG_MS)) begin
                            state_d = REPEAT;
                            rep_d   = '0;
                            held_d  = 1'b1;
                            press   = 1'b1;
                        end
                    end
                end
                REPEAT: begin
                    if (!pressed) begin
                        state_d = DEB_RELEASE;
                        deb_d   = '0;
                    end else if (tick) begin
                        if (rep_q == RW'(REPEAT_MS - 1)) begin
                            rep_d = '0;
                            press = 1'b1;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end
                end
                DEB_RELEASE: begin
                    // A release glitch returns to wherever the press was, silently.
                    if (pressed) begin
                        state_d = held_q ? REPEAT : PRESSED;
                    end else if (tick) begin
                        deb_d = deb_sat;
                        if (deb_sat == DW'(DEBOUNCE_MS)) begin
                            state_d   = IDLE;
                            held_d    = 1'b0;
                            rel_pulse = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge sclk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
                deb_q   <= '0;
                long_q  <= '0;
                rep_q   <= '0;
                held_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                deb_q   <= deb_d;
                long_q  <= long_d;
                rep_q   <= rep_d;
                held_q  <= held_d;
            end
        end

        assign key_press[g]   = press;
        assign key_release[g] = rel_pulse;
        assign key_held[g]    = held_q;

`ifdef KEY_BANK_DCLICK_EN
        localparam int WW = $clog2(DCLICK_MS + 1);
        logic [WW-1:0] win_q;
        logic          win_act_q;
        logic          first_press;

        // Only the debounced press can start a double click; repeats come from PRESSED/REPEAT.
        assign first_press = press && (state_q == DEB_PRESS);

        always_ff @(posedge sclk or posedge rst) begin
            if (rst) begin
                win_q     <= '0;
                win_act_q <= 1'b0;
            end else if (rel_pulse) begin
                win_q     <= '0;
                win_act_q <= 1'b1;
            end else if (first_press) begin
                win_act_q <= 1'b0;
            end else if (tick && win_act_q && (win_q != WW'(DCLICK_MS))) begin
                win_q <= win_q + 1'b1;
            end
        end

        assign key_dclick[g] = first_press && win_act_q && (win_q < WW'(DCLICK_MS));
`else
        assign key_dclick[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_key_bank.sv
// Scoreboard bench for key_bank: each stimulus step queues the pulse vectors it
// should cause together with a cycle window; a negedge monitor pops and compares.
module tb_key_bank;

    localparam int CH = 4;
    localparam int MS = 10;  // sclk cycles per millisecond tick at CLK_FREQ = 10_000

`ifdef KEY_BANK_DCLICK_EN
    localparam logic [CH-1:0] DC3 = 4'b1000;
`else
    localparam logic [CH-1:0] DC3 = 4'b0000;
`endif

    logic          sclk = 1'b0;
    logic          rst  = 1'b1;
    logic [CH-1:0] key_in = '1;
    logic [CH-1:0] key_press, key_release, key_held, key_dclick;

    typedef struct {
        logic [CH-1:0] press;
        logic [CH-1:0] rel;
        logic [CH-1:0] dclick;
        int            lo;
        int            hi;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    key_bank #(
        .CLK_FREQ (10_000),
        .CH       (CH)
    ) dut (
        .sclk        (sclk),
        .rst         (rst),
        .key_in      (key_in),
        .key_press   (key_press),
        .key_release (key_release),
        .key_held    (key_held),
        .key_dclick  (key_dclick)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // A debounce completes 19-20 ticks after the synchroniser sees the edge.
    task automatic expect_ev(input logic [CH-1:0] p, input logic [CH-1:0] r,
                             input logic [CH-1:0] d, input int base);
        exp_q.push_back('{press: p, rel: r, dclick: d, lo: base + 188, hi: base + 206});
    endtask

    task automatic wait_ms(input int n);
        repeat (n * MS) @(posedge sclk);
        #1;
    endtask

    always @(negedge sclk) begin
        exp_t e;
        int   want;
        if (!rst && ((key_press | key_release | key_dclick) != '0)) begin
            check("press_release_overlap", 32'(key_press & key_release), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {20'd0, key_press, key_release, key_dclick}, 0);
            end else begin
                e    = exp_q.pop_front();
                want = (cyc < e.lo) ? e.lo : ((cyc > e.hi) ? e.hi : cyc);
                check("press_vec", 32'(key_press), 32'(e.press));
                check("release_vec", 32'(key_release), 32'(e.rel));
                check("dclick_vec", 32'(key_dclick), 32'(e.dclick));
                check("pulse_time", cyc, want);
            end
        end
    end

    initial begin
        int c;

        repeat (3) @(posedge sclk);
        #1;
        check("reset_outputs", {16'd0, key_press, key_release, key_held, key_dclick}, 0);
        rst = 1'b0;
        wait_ms(5);
        check("idle_outputs", {16'd0, key_press, key_release, key_held, key_dclick}, 0);

        // Ch0: short press, one press pulse and one release pulse, never held.
        key_in[0] = 1'b0;
        expect_ev(4'b0001, 4'b0000, 4'b0000, cyc);
        wait_ms(50);
        check("ch0_held", 32'(key_held), 0);
        key_in[0] = 1'b1;
        expect_ev(4'b0000, 4'b0001, 4'b0000, cyc);
        wait_ms(50);

        // Ch1: bounces too short to debounce, then a real 30 ms press.
        for (int i = 0; i < 5; i++) begin
            key_in[1] = 1'b0;
            wait_ms(2);
            key_in[1] = 1'b1;
            wait_ms(2);
        end
        key_in[1] = 1'b0;
        expect_ev(4'b0010, 4'b0000, 4'b0000, cyc);
        wait_ms(30);
        key_in[1] = 1'b1;
        expect_ev(4'b0000, 4'b0010, 4'b0000, cyc);
        wait_ms(40);

        // Ch2: 1000 ms hold gives press, long press, then repeats every 100 ms.
        key_in[2] = 1'b0;
        c = cyc;
        expect_ev(4'b0100, 4'b0000, 4'b0000, c);
        for (int k = 0; k < 5; k++)
            expect_ev(4'b0100, 4'b0000, 4'b0000, c + 5000 + k * 1000);
        wait_ms(30);
        check("ch2_held_early", 32'(key_held), 0);
        wait_ms(570);
        check("ch2_held_long", 32'(key_held), 32'(4'b0100));
        wait_ms(400);
        key_in[2] = 1'b1;
        expect_ev(4'b0000, 4'b0100, 4'b0000, cyc);
        wait_ms(10);
        check("ch2_held_deb_release", 32'(key_held), 32'(4'b0100));
        wait_ms(40);
        check("ch2_held_cleared", 32'(key_held), 0);

        // Ch3: 100 ms gap is a double click, 400 ms gap is not.
        key_in[3] = 1'b0;
        expect_ev(4'b1000, 4'b0000, 4'b0000, cyc);
        wait_ms(50);
        key_in[3] = 1'b1;
        expect_ev(4'b0000, 4'b1000, 4'b0000, cyc);
        wait_ms(100);
        key_in[3] = 1'b0;
        expect_ev(4'b1000, 4'b0000, DC3, cyc);
        wait_ms(50);
        key_in[3] = 1'b1;
        expect_ev(4'b0000, 4'b1000, 4'b0000, cyc);
        wait_ms(400);
        key_in[3] = 1'b0;
        expect_ev(4'b1000, 4'b0000, 4'b0000, cyc);
        wait_ms(50);
        key_in[3] = 1'b1;
        expect_ev(4'b0000, 4'b1000, 4'b0000, cyc);
        wait_ms(50);

        // Reset while ch0 auto-repeats: outputs drop at once, no release, fresh debounce.
        key_in[0] = 1'b0;
        c = cyc;
        expect_ev(4'b0001, 4'b0000, 4'b0000, c);
        expect_ev(4'b0001, 4'b0000, 4'b0000, c + 5000);
        wait_ms(600);
        check("ch0_held_repeat", 32'(key_held), 32'(4'b0001));
        rst = 1'b1;
        #1;
        check("rst_async_outputs", {16'd0, key_press, key_release, key_held, key_dclick}, 0);
        repeat (3) @(posedge sclk);
        #1;
        rst = 1'b0;
        expect_ev(4'b0001, 4'b0000, 4'b0000, cyc);
        wait_ms(100);
        check("ch0_held_after_rst", 32'(key_held), 0);
        key_in[0] = 1'b1;
        expect_ev(4'b0000, 4'b0001, 4'b0000, cyc);
        wait_ms(400);

        // All channels pressed together pulse in the same cycle.
        key_in = '0;
        expect_ev(4'b1111, 4'b0000, 4'b0000, cyc);
        wait_ms(50);
        key_in = '1;
        expect_ev(4'b0000, 4'b1111, 4'b0000, cyc);
        wait_ms(50);

        check("missing_pulses", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
